// File: rtl/bin_to_bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble, one bit per clock).
// Define BIN_TO_BCD_BLANK_EN to replace leading zero digits with 4'hF on dout.
module bin_to_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] din,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] dout,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [13:0] shift_q, shift_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        big_q, big_d;
  logic [15:0] dout_q, dout_d;
  logic        ovf_q, ovf_d;

  logic [15:0] bcd_adj;
  logic [15:0] bcd_step;
  logic [15:0] bcd_fmt;

  // Add-3 correction on every digit, then shift in the next binary MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_step = {bcd_adj[14:0], shift_q[13]};
  end

`ifdef BIN_TO_BCD_BLANK_EN
  function automatic logic [15:0] blank_lz(input logic [15:0] v);
    logic [15:0] r;
    logic        lead;
    r    = v;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  assign bcd_fmt = blank_lz(bcd_step);
`else
  assign bcd_fmt = bcd_step;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    big_d   = big_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d = din;
          bcd_d   = 16'h0000;
          cnt_d   = 4'd0;
          big_d   = (din > 14'd9999);
          state_d = StShift;
        end
      end
      StShift: begin
        shift_d = {shift_q[12:0], 1'b0};
        bcd_d   = bcd_step;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          // Output registers load only here, so partial sums never reach dout.
          dout_d  = big_q ? 16'hFFFF : bcd_fmt;
          ovf_d   = big_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= 14'd0;
      bcd_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      big_q   <= 1'b0;
      dout_q  <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      big_q   <= big_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed vector table plus latency, backpressure,
// ignored-input, reset and throughput sequences.
module tb_bin_to_bcd;

  logic        clk;
  logic        rst_n;
  logic [13:0] din;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dout;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  int n_total;
  int n_pass;
  int cyc;

  bin_to_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          val;
    logic [15:0] raw;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [15:0] fmt(input logic [15:0] raw);
    logic [15:0] r;
    r = raw;
`ifdef BIN_TO_BCD_BLANK_EN
    if (r[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (r[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (r[7:4] == 4'd0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [15:0] model(input int v);
    logic [15:0] raw;
    if (v > 9999) return 16'hFFFF;
    raw[15:12] = 4'(v / 1000);
    raw[11:8]  = 4'((v / 100) % 10);
    raw[7:4]   = 4'((v / 10) % 10);
    raw[3:0]   = 4'(v % 10);
    return fmt(raw);
  endfunction

  // Full conversion with out_ready high; checks exact latency and return to IDLE.
  task automatic run_one(input int v, input logic [15:0] exp_dout, input logic exp_ovf,
                         input string name);
    @(negedge clk);
    din       = 14'(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({name, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = ~14'(v);
    repeat (13) @(posedge clk);
    #1;
    chk({name, "_early"}, {15'd0, out_valid}, 16'd0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, {15'd0, out_valid}, 16'd1);
    chk({name, "_dout"}, dout, exp_dout);
    chk({name, "_ovf"}, {15'd0, ovf}, {15'd0, exp_ovf});
    @(posedge clk);
    #1;
    chk({name, "_idle"}, {14'd0, in_ready, out_valid}, 16'b10);
  endtask

  initial begin
    vec_t vecs[11];
    logic [15:0] prev_dout;
    int          seen;
    int          hs_cyc;
    int          last_hs;
    int          v;

    vecs[0]  = '{42,    16'h0042, 1'b0};
    vecs[1]  = '{0,     16'h0000, 1'b0};
    vecs[2]  = '{9999,  16'h9999, 1'b0};
    vecs[3]  = '{10000, 16'hFFFF, 1'b1};
    vecs[4]  = '{16383, 16'hFFFF, 1'b1};
    vecs[5]  = '{1234,  16'h1234, 1'b0};
    vecs[6]  = '{5,     16'h0005, 1'b0};
    vecs[7]  = '{1000,  16'h1000, 1'b0};
    vecs[8]  = '{8765,  16'h8765, 1'b0};
    vecs[9]  = '{909,   16'h0909, 1'b0};
    vecs[10] = '{10,    16'h0010, 1'b0};

    n_total   = 0;
    n_pass    = 0;
    cyc       = 0;
    din       = 14'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("reset_state", {ovf, out_valid, in_ready, 13'd0}, {3'b001, 13'd0});
    chk("reset_dout", dout, 16'h0000);
    #12;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_one(vecs[i].val, vecs[i].ovf ? 16'hFFFF : fmt(vecs[i].raw), vecs[i].ovf,
              $sformatf("vec%0d", vecs[i].val));
    end

    // Backpressure: result held for 5 cycles with out_ready low.
    @(negedge clk);
    din       = 14'd1234;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("bp_valid", {15'd0, out_valid}, 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_dout", dout, fmt(16'h1234));
      chk("bp_hold", {14'd0, out_valid, in_ready}, 16'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {14'd0, out_valid, in_ready}, 16'b01);

    // Inputs wiggled during SHIFT must not disturb the captured value.
    @(negedge clk);
    din      = 14'd4321;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      din       = 14'($urandom);
      in_valid  = ~in_valid;
      out_ready = ~out_ready;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ign_valid", {15'd0, out_valid}, 16'd1);
    chk("ign_dout", dout, fmt(16'h4321));
    chk("ign_ovf", {15'd0, ovf}, 16'd0);
    @(posedge clk);

    // Reset between edges mid-SHIFT: immediate clear, no result afterwards.
    @(negedge clk);
    din      = 14'd777;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", {14'd0, out_valid, in_ready}, 16'b01);
    chk("rst_async_dout", dout, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("rst_no_result", 16'(seen), 16'd0);

    // Handshake accepted on the very first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    din      = 14'd77;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rel_hs", {15'd0, in_ready}, 16'd0);
    repeat (14) @(posedge clk);
    #1;
    chk("rel_valid", {15'd0, out_valid}, 16'd1);
    chk("rel_dout", dout, fmt(16'h0077));

    // Throughput: in_valid held high, one conversion every 16 cycles.
    @(posedge clk);
    in_valid = 1'b1;
    last_hs  = -1;
    for (int k = 0; k < 100; k++) begin
      v = int'($urandom_range(0, 9999));
      @(negedge clk);
      din = 14'(v);
      @(posedge clk);
      hs_cyc = cyc;
      #1;
      chk("tp_hs", {15'd0, in_ready}, 16'd0);
      if (last_hs >= 0) chk("tp_period", 16'(hs_cyc - last_hs), 16'd16);
      last_hs = hs_cyc;
      repeat (14) @(posedge clk);
      #1;
      chk("tp_valid", {15'd0, out_valid}, 16'd1);
      chk("tp_dout", dout, model(v));
      prev_dout = dout;
      @(posedge clk);
      #1;
      chk("tp_idle", {15'd0, in_ready}, 16'd1);
      chk("tp_dout_hold", dout, prev_dout);
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
